// File: rtl/program_loader.sv
// Program RAM loader: accepts a byte stream, writes it through the shared CPU bus
// (MAR load, then RAM write) while the CPU is held, then restarts the CPU at address 0.
module program_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int WORDS  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              mar_load,
   output logic              ram_we,
   output logic              cpu_hold,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_SETADDR = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_NEXT    = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(WORDS);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W:0]   count_q, count_d;

   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] bus_out_q, bus_out_d;
   logic              bus_oe_q, bus_oe_d;
   logic              mar_load_q, mar_load_d;
   logic              ram_we_q, ram_we_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      data_d  = data_q;
      count_d = count_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
               addr_d  = '0;
               count_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (in_valid && in_ready_q) begin
               data_d  = in_data;
               state_d = S_SETADDR;
            end
         end
         S_SETADDR: state_d = S_WRITE;
         S_WRITE:   state_d = S_NEXT;
         S_NEXT: begin
            count_d = count_q + (ADDR_W+1)'(1);
            if (count_d == len_q) begin
               state_d = S_RELEASE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_WAIT;
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies line up
      // with the state they describe.
      in_ready_d  = (state_d == S_WAIT);
      mar_load_d  = (state_d == S_SETADDR);
      ram_we_d    = (state_d == S_WRITE);
      bus_oe_d    = mar_load_d || ram_we_d;
      cpu_hold_d  = (state_d != S_IDLE);
      busy_d      = (state_d != S_IDLE);
      cpu_reset_d = (state_d == S_RELEASE);
      done_d      = (state_d == S_RELEASE);
      bus_out_d   = '0;
      if (mar_load_d) bus_out_d = DATA_W'(addr_d);
      if (ram_we_d)   bus_out_d = data_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         bus_out_q   <= '0;
         bus_oe_q    <= 1'b0;
         mar_load_q  <= 1'b0;
         ram_we_q    <= 1'b0;
         cpu_hold_q  <= 1'b0;
         cpu_reset_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         bus_out_q   <= bus_out_d;
         bus_oe_q    <= bus_oe_d;
         mar_load_q  <= mar_load_d;
         ram_we_q    <= ram_we_d;
         cpu_hold_q  <= cpu_hold_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign bus_out   = bus_out_q;
   assign bus_oe    = bus_oe_q;
   assign mar_load  = mar_load_q;
   assign ram_we    = ram_we_q;
   assign cpu_hold  = cpu_hold_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU's program RAM. The controller fetches and executes from the 16-word RAM; this block fills that RAM beforehand.
- Accepts a byte stream over a valid/ready handshake. Holds the CPU halted while loading.
- Writes each byte through the shared bus using the MAR-load and RAM-write strobes, then releases the CPU with a one-cycle restart pulse so execution begins at address 0.

Parameters:
- ADDR_W, 4, RAM address width (MAR width)
- DATA_W, 8, bus/RAM word width
- WORDS, 16, RAM depth (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (low = reset)
- start  input  1  begin a load session; sampled in IDLE only
- len  input  ADDR_W+1  number of words to load, latched at start; 0 means WORDS
- in_valid  input  1  source has a byte on in_data
- in_data  input  DATA_W  program byte
- in_ready  output  1  loader accepts in_data this cycle
- bus_out  output  DATA_W  value the loader drives onto the CPU bus
- bus_oe  output  1  loader owns the bus (top level muxes bus_out in)
- mar_load  output  1  MAR load strobe
- ram_we  output  1  RAM write strobe
- cpu_hold  output  1  forces CPU clock gate/halt while high
- cpu_reset  output  1  one-cycle CPU restart pulse (PC and state to 0)
- busy  output  1  session in progress
- done  output  1  one-cycle pulse at session end
- count  output  ADDR_W+1  words written in the current or last session

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; all outputs 0. This includes cpu_hold=0 and count=0.
- Reset takes effect immediately, even mid-session. After release the block sits in IDLE and the RAM contents are left as written.

States:
- IDLE
  - All strobes 0.
  - When start=1: latch len (0 maps to WORDS), clear addr and count, set cpu_hold=1 and busy=1, go to WAIT.
- WAIT
  - in_ready=1.
  - On in_valid && in_ready: latch in_data, go to SETADDR. in_ready drops the next cycle.
  - With no valid, stay in WAIT indefinitely.
- SETADDR
  - bus_out={0,addr}, bus_oe=1, mar_load=1.
  - Go to WRITE.
- WRITE
  - bus_out=latched byte, bus_oe=1, ram_we=1, mar_load=0.
  - Go to NEXT.
- NEXT
  - bus_oe=0, ram_we=0.
  - count increments by 1.
  - If count+1 == latched len: go to RELEASE. Otherwise addr increments and the block goes to WAIT.
- RELEASE
  - cpu_reset=1 and done=1 for exactly one cycle.
  - cpu_hold=0 and busy=0 from the following cycle.
  - Go to IDLE.

Rules:
- Throughput is 4 cycles per byte (WAIT, SETADDR, WRITE, NEXT) with in_valid held high continuously.
- First byte: latency from acceptance to the ram_we strobe is 2 cycles.
- mar_load and ram_we are never high in the same cycle.
- bus_oe is high only in SETADDR and WRITE.
- in_ready is high only in WAIT.
- start outside IDLE is ignored. in_valid outside WAIT is ignored, and the byte is not consumed.
- addr is ADDR_W bits and never wraps within a session. len=WORDS ends the session at address WORDS-1.
- len values greater than WORDS are clamped to WORDS.
- cpu_hold stays high continuously from the IDLE→WAIT edge through the RELEASE cycle inclusive.
- count holds its final value after done, until the next start.

Test Plan:
- Three-word load: reset, start with len=3, bytes 0x1E, 0x2F, 0xF0 presented with in_valid held high → mar_load with bus_out 0x00, 0x01, 0x02, each followed next cycle by ram_we with bus_out 0x1E, 0x2F, 0xF0. Expect 4 cycles per byte, done pulse, count=3, a single cpu_reset pulse, then cpu_hold=0.
- Full depth: len=0 → 16 writes to addresses 0x0..0xF, count=16, no write to address 0 after address 15.
- Backpressure and gaps: in_valid toggled 1-0-0-1 with len=2 → the block waits in WAIT with in_ready=1 and no strobes during gaps. Exactly 2 writes occur, and the data order is preserved.
- Start during busy: start pulsed again mid-session, with len input changed to 5 → ignored; the session completes with the original len.
- Reset mid-load: reset asserted low during a WRITE cycle of the 2nd byte → all outputs 0 asynchronously, including cpu_hold=0. After release the block is in IDLE. A new start with len=1 writes address 0.
- Strobe exclusivity: assertion checked throughout all tests → never (mar_load && ram_we), never bus_oe outside SETADDR/WRITE, in_ready only in WAIT.
